// File: rtl/cmp_pkg.sv
// Shared definitions for the compare-unit arbiter:
// FSM state encoding and compare function codes.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] CMP_NONE = 2'b00;
   localparam logic [1:0] CMP_EQ   = 2'b01;
   localparam logic [1:0] CMP_GT   = 2'b10;
   localparam logic [1:0] CMP_LT   = 2'b11;

endpackage

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of a shared compare unit,
// one command in flight, with a bounded wait for the unit's result.
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_in1,
   input  logic [DATA_WIDTH-1:0] req0_in2,
   input  logic [1:0]            req0_fun,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_in1,
   input  logic [DATA_WIDTH-1:0] req1_in2,
   input  logic [1:0]            req1_fun,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] cmp_in1,
   output logic [DATA_WIDTH-1:0] cmp_in2,
   output logic [1:0]            cmp_fun,
   output logic                  cmp_en,
   input  logic [DATA_WIDTH-1:0] cmp_out,
   input  logic                  cmp_flag
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t                state;
   logic                  prio;
   logic                  gnt;
   logic [DATA_WIDTH-1:0] lat_in1;
   logic [DATA_WIDTH-1:0] lat_in2;
   logic [1:0]            lat_fun;
   logic [CW-1:0]         cnt;

   logic                  pick;
   logic                  rsp_take;

   // prio=1 means requester 1 wins a tie
   always_comb begin
      pick = 1'b0;
      if (req1_valid && (!req0_valid || prio))
         pick = 1'b1;
   end

   assign rsp_take = gnt ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         prio       <= 1'b0;
         gnt        <= 1'b0;
         lat_in1    <= '0;
         lat_in2    <= '0;
         lat_fun    <= CMP_NONE;
         cnt        <= '0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         cmp_in1    <= '0;
         cmp_in2    <= '0;
         cmp_fun    <= CMP_NONE;
         cmp_en     <= 1'b0;
      end else begin
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         cmp_en     <= 1'b0;
         unique case (state)
            IDLE: begin
               // grant cycle shows ready; the following edge issues
               if (req0_ready || req1_ready) begin
                  state   <= ISSUE;
                  cmp_en  <= 1'b1;
                  cmp_in1 <= lat_in1;
                  cmp_in2 <= lat_in2;
                  cmp_fun <= lat_fun;
               end else if (req0_valid || req1_valid) begin
                  gnt        <= pick;
                  prio       <= ~pick;
                  req0_ready <= ~pick;
                  req1_ready <= pick;
                  lat_in1    <= pick ? req1_in1 : req0_in1;
                  lat_in2    <= pick ? req1_in2 : req0_in2;
                  lat_fun    <= pick ? req1_fun : req0_fun;
               end
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               if (cmp_flag) begin
                  rsp_data   <= cmp_out;
                  rsp_err    <= 1'b0;
                  rsp0_valid <= ~gnt;
                  rsp1_valid <= gnt;
                  state      <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_data   <= '0;
                  rsp_err    <= 1'b1;
                  rsp0_valid <= ~gnt;
                  rsp1_valid <= gnt;
                  state      <= RESP;
               end else if (cnt != CW'(TIMEOUT)) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_take) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a one-cycle compare unit model
// that returns the function code when the comparison holds, else 0.
module tb_cmp_arbiter;
   import cmp_pkg::*;

   localparam int DW = 16;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_valid = 1'b0;
   logic          req0_ready;
   logic [DW-1:0] req0_in1 = '0;
   logic [DW-1:0] req0_in2 = '0;
   logic [1:0]    req0_fun = CMP_NONE;
   logic          req1_valid = 1'b0;
   logic          req1_ready;
   logic [DW-1:0] req1_in1 = '0;
   logic [DW-1:0] req1_in2 = '0;
   logic [1:0]    req1_fun = CMP_NONE;
   logic          rsp0_valid;
   logic          rsp0_ready = 1'b0;
   logic          rsp1_valid;
   logic          rsp1_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [DW-1:0] cmp_in1;
   logic [DW-1:0] cmp_in2;
   logic [1:0]    cmp_fun;
   logic          cmp_en;
   logic [DW-1:0] cmp_out;
   logic          cmp_flag;
   logic          nofl = 1'b0;

   int errs = 0;
   int checks = 0;
   int cyc;

   always #5 clk = ~clk;

   cmp_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_fun(req0_fun),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_fun(req1_fun),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_fun(cmp_fun),
      .cmp_en(cmp_en), .cmp_out(cmp_out), .cmp_flag(cmp_flag)
   );

   function automatic logic [DW-1:0] unit_res(
      input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic [1:0] f);
      logic hit;
      hit = 1'b0;
      case (f)
         CMP_EQ:  hit = (a == b);
         CMP_GT:  hit = (a > b);
         CMP_LT:  hit = (a < b);
         default: hit = 1'b0;
      endcase
      return hit ? DW'(f) : '0;
   endfunction

   always_ff @(posedge clk or negedge rst) begin : cmp_unit
      if (!rst) begin
         cmp_flag <= 1'b0;
         cmp_out  <= '0;
      end else begin
         cmp_flag <= cmp_en & ~nofl;
         cmp_out  <= cmp_en ? unit_res(cmp_in1, cmp_in2, cmp_fun) : '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int k);
      case (k)
         0:       return req0_ready;
         1:       return req1_ready;
         2:       return rsp0_valid;
         default: return rsp1_valid;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int k,
                           input int budget, output int n);
      n = 1;
      @(negedge clk);
      while (!sig(k) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(sig(k)), 32'd1);
   endtask

   task automatic zero_outs(input string tag);
      check({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      check({tag, "_vld"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check({tag, "_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_cmp"}, {cmp_en, cmp_fun, cmp_in1, cmp_in2}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      zero_outs("rst");
      rst = 1'b1;
      @(negedge clk);

      // single eq command, latency and hold of operands
      req0_valid = 1'b1; req0_fun = CMP_EQ; req0_in1 = 5; req0_in2 = 5;
      wait_sig("eq_rdy", 0, 4, cyc);
      check("eq_rdy_cyc", cyc, 1);
      check("eq_en0", 32'(cmp_en), 0);
      req0_valid = 1'b0;
      @(negedge clk);
      check("eq_en1", 32'(cmp_en), 1);
      check("eq_ops", {cmp_fun, cmp_in1[7:0], cmp_in2[7:0]}, {2'd1, 8'd5, 8'd5});
      check("eq_rdy_low", 32'(req0_ready), 0);
      @(negedge clk);
      check("eq_en2", 32'(cmp_en), 0);
      check("eq_fun_hold", 32'(cmp_fun), 1);
      check("eq_vld_early", 32'(rsp0_valid), 0);
      @(negedge clk);
      check("eq_vld", {rsp1_valid, rsp0_valid}, 32'b01);
      check("eq_data", 32'(rsp_data), 1);
      check("eq_err", 32'(rsp_err), 0);
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      check("eq_done", 32'(rsp0_valid), 0);

      // reset restores requester-0 priority and clears the result
      rst = 1'b0;
      #1 zero_outs("rst2");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // both valid: req0 wins, req1 waits
      req0_valid = 1'b1; req0_fun = CMP_GT; req0_in1 = 9; req0_in2 = 3;
      req1_valid = 1'b1; req1_fun = CMP_LT; req1_in1 = 2; req1_in2 = 7;
      wait_sig("rr_rdy0", 0, 4, cyc);
      check("rr_rdy1_low", 32'(req1_ready), 0);
      req0_valid = 1'b0;
      wait_sig("rr_vld0", 2, 8, cyc);
      check("rr_lat0", cyc, 3);
      check("rr_data0", 32'(rsp_data), 2);
      rsp1_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_vld", {rsp1_valid, rsp0_valid}, 32'b01);
         check("hold_data", 32'(rsp_data), 2);
         check("hold_nogrant", 32'(req1_ready), 0);
      end
      rsp1_ready = 1'b0;
      rsp0_ready = 1'b1;
      wait_sig("rr_rdy1", 1, 6, cyc);
      rsp0_ready = 1'b0;
      check("rr_rdy1_cyc", cyc, 2);
      check("rr_vld0_off", 32'(rsp0_valid), 0);
      req1_valid = 1'b0;
      wait_sig("rr_vld1", 3, 8, cyc);
      check("rr_lat1", cyc, 3);
      check("rr_data1", 32'(rsp_data), 3);
      check("rr_vld0_x", 32'(rsp0_valid), 0);
      rsp1_ready = 1'b1;
      @(negedge clk);
      rsp1_ready = 1'b0;
      check("rr_done1", 32'(rsp1_valid), 0);

      // compare unit never answers: timeout after four WAIT cycles
      nofl = 1'b1;
      req0_valid = 1'b1; req0_fun = CMP_GT; req0_in1 = 9; req0_in2 = 3;
      wait_sig("to_rdy", 0, 4, cyc);
      req0_valid = 1'b0;
      wait_sig("to_vld", 2, 12, cyc);
      check("to_lat", cyc, 6);
      check("to_data", 32'(rsp_data), 0);
      check("to_err", 32'(rsp_err), 1);
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      nofl = 1'b0;

      // reset during WAIT abandons the command
      req0_valid = 1'b1; req0_fun = CMP_EQ; req0_in1 = 7; req0_in2 = 7;
      wait_sig("mid_rdy", 0, 4, cyc);
      req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 zero_outs("mid");
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_sig("mid_rdy0", 0, 4, cyc);
      check("mid_rdy0_cyc", cyc, 1);
      check("mid_rdy1_low", 32'(req1_ready), 0);
      check("mid_no_rsp", {rsp1_valid, rsp0_valid}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
